mem_stage: RTL and testbench

Pipeline MEM stage of the MIPS core, sitting between the EX/MEM pipeline register and the byte-lane data RAM (`enabler`, `write_enabler`, `addr`, `select`, `data_input`, `data_output`). It decodes the load/store op into RAM enables, byte selects and lane-replicated store data. It aligns and sign/zero-extends the combinational RAM read data and detects misaligned accesses. It registers the result into the MEM/WB register and holds the LL/SC link bit.

---
 rtl/mem_stage.sv | 158 +++++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM pipeline stage. Decodes load/store ops into byte-lane
// RAM controls, aligns and extends read data, detects misaligned accesses,
// and registers the result into the MEM/WB register.
// Optional feature macro: MEM_STAGE_LLSC_EN (LL/SC support with a link bit).
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        ll_clear,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_store_data,
   input  logic [31:0] alu_result_in,
   input  logic [4:0]  wd_in,
   input  logic        wreg_in,
   output logic        ram_enabler,
   output logic        ram_write_enabler,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_select,
   output logic [31:0] ram_data_input,
   input  logic [31:0] ram_data_output,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic [31:0] bad_vaddr
);

   typedef enum logic [1:0] {SZ_NONE = 2'd0, SZ_BYTE = 2'd1, SZ_HALF = 2'd2, SZ_WORD = 2'd3} size_t;

   logic        is_load, is_store, is_sext, is_ll, is_sc, is_kill;
   size_t       size;
   logic        misalign, link, sc_fail, commit;
   logic [4:0]  lane_shift;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [31:0] wdata_next;
   logic        wreg_next;

   // Op decode
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_sext  = 1'b0;
      is_ll    = 1'b0;
      is_sc    = 1'b0;
      is_kill  = 1'b0;
      size     = SZ_NONE;
      case (mem_op)
         4'd1:  begin is_load = 1'b1; size = SZ_BYTE; is_sext = 1'b1; end
         4'd2:  begin is_load = 1'b1; size = SZ_BYTE; end
         4'd3:  begin is_load = 1'b1; size = SZ_HALF; is_sext = 1'b1; end
         4'd4:  begin is_load = 1'b1; size = SZ_HALF; end
         4'd5:  begin is_load = 1'b1; size = SZ_WORD; end
         4'd6:  begin is_store = 1'b1; size = SZ_BYTE; end
         4'd7:  begin is_store = 1'b1; size = SZ_HALF; end
         4'd8:  begin is_store = 1'b1; size = SZ_WORD; end
`ifdef MEM_STAGE_LLSC_EN
         4'd9:  begin is_load = 1'b1; size = SZ_WORD; is_ll = 1'b1; end
         4'd10: begin is_store = 1'b1; size = SZ_WORD; is_sc = 1'b1; end
`else
         4'd9, 4'd10: is_kill = 1'b1;
`endif
         default: ;
      endcase
   end

   // Alignment check, commit qualifier and SC outcome
   always_comb begin
      misalign = ((size == SZ_HALF) && mem_addr[0]) ||
                 ((size == SZ_WORD) && (mem_addr[1:0] != 2'b00));
      commit   = !stall && !flush;
      sc_fail  = is_sc && !link;
   end

   // RAM request: lane selects, replicated store data, enables
   always_comb begin
      ram_addr = mem_addr;
      case (size)
         SZ_BYTE: begin
            ram_select     = 4'b1000 >> mem_addr[1:0];
            ram_data_input = {4{mem_store_data[7:0]}};
         end
         SZ_HALF: begin
            ram_select     = mem_addr[1] ? 4'b0011 : 4'b1100;
            ram_data_input = {2{mem_store_data[15:0]}};
         end
         SZ_WORD: begin
            ram_select     = 4'b1111;
            ram_data_input = mem_store_data;
         end
         default: begin
            ram_select     = 4'b0000;
            ram_data_input = mem_store_data;
         end
      endcase
      ram_write_enabler = !rst && !misalign && is_store && !sc_fail && commit;
      ram_enabler       = !rst && !misalign && (is_load || ram_write_enabler);
   end

   // Read-data lane extraction (lane 0 is the most significant byte)
   always_comb begin
      lane_shift = {~mem_addr[1:0], 3'b000};
      byte_val   = 8'(ram_data_output >> lane_shift);
      half_val   = mem_addr[1] ? ram_data_output[15:0] : ram_data_output[31:16];
      wdata_next = alu_result_in;
      if (is_load) begin
         case (size)
            SZ_BYTE: wdata_next = is_sext ? {{24{byte_val[7]}}, byte_val} : {24'h0, byte_val};
            SZ_HALF: wdata_next = is_sext ? {{16{half_val[15]}}, half_val} : {16'h0, half_val};
            default: wdata_next = ram_data_output;
         endcase
      end else if (is_sc) begin
         wdata_next = {31'h0, link};
      end
      wreg_next = wreg_in && !misalign && !is_kill;
   end

   // MEM/WB register: flush squashes, stall holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_wd     <= 5'd0;
         wb_wreg   <= 1'b0;
         wb_wdata  <= 32'd0;
         exc_adel  <= 1'b0;
         exc_ades  <= 1'b0;
         bad_vaddr <= 32'd0;
      end else if (flush) begin
         wb_wreg  <= 1'b0;
         exc_adel <= 1'b0;
         exc_ades <= 1'b0;
      end else if (!stall) begin
         wb_wd    <= wd_in;
         wb_wreg  <= wreg_next;
         wb_wdata <= wdata_next;
         exc_adel <= misalign && is_load;
         exc_ades <= misalign && is_store;
         if (misalign) bad_vaddr <= mem_addr;
      end
   end

`ifdef MEM_STAGE_LLSC_EN
   // Link bit: set by committed LL, cleared by committed SC or ll_clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                link <= 1'b0;
      else if (ll_clear)                      link <= 1'b0;
      else if (commit && is_ll && !misalign)  link <= 1'b1;
      else if (commit && is_sc)               link <= 1'b0;
   end
`else
   logic unused_ll_clear;
   assign link            = 1'b0;
   assign unused_ll_clear = ll_clear;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst, stall, flush, ll_clear, wreg_in;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr, mem_store_data, alu_result_in, ram_data_output;
   logic [4:0]  wd_in;
   logic        ram_enabler, ram_write_enabler;
   logic [31:0] ram_addr, ram_data_input;
   logic [3:0]  ram_select;
   logic [4:0]  wb_wd;
   logic        wb_wreg, exc_adel, exc_ades;
   logic [31:0] wb_wdata, bad_vaddr;
   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ll_clear(ll_clear),
      .mem_op(mem_op), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
      .alu_result_in(alu_result_in), .wd_in(wd_in), .wreg_in(wreg_in),
      .ram_enabler(ram_enabler), .ram_write_enabler(ram_write_enabler),
      .ram_addr(ram_addr), .ram_select(ram_select), .ram_data_input(ram_data_input),
      .ram_data_output(ram_data_output), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
      .wb_wdata(wb_wdata), .exc_adel(exc_adel), .exc_ades(exc_ades), .bad_vaddr(bad_vaddr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] wd, input logic wr);
      mem_op = op; mem_addr = addr; wd_in = wd; wreg_in = wr;
      #1;
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0; ll_clear = 1'b0; wreg_in = 1'b0;
      mem_op = 4'd0; mem_addr = 32'd0; mem_store_data = 32'd0;
      alu_result_in = 32'd0; ram_data_output = 32'd0; wd_in = 5'd0;
      #2 rst = 1'b1;
      #1;
      chk("rst_wreg", 32'(wb_wreg), 32'd0);
      chk("rst_wdata", wb_wdata, 32'd0);
      chk("rst_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
      chk("rst_vaddr", bad_vaddr, 32'd0);
      tick();
      rst = 1'b0;

      // SB byte lane 2
      mem_store_data = 32'h0000_00AB;
      drive(4'd6, 32'h1000_0002, 5'd0, 1'b0);
      chk("sb_sel", 32'(ram_select), 32'h2);
      chk("sb_din", ram_data_input, 32'hABAB_ABAB);
      chk("sb_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h3);
      chk("sb_addr", ram_addr, 32'h1000_0002);
      tick();

      // SH / SW lane replication
      mem_store_data = 32'h1234_5678;
      drive(4'd7, 32'h0000_0002, 5'd0, 1'b0);
      chk("sh_sel", 32'(ram_select), 32'h3);
      chk("sh_din", ram_data_input, 32'h5678_5678);

      // Loads from RAM word 0x80FF7F01
      ram_data_output = 32'h80FF_7F01;
      drive(4'd1, 32'h0000_0000, 5'd5, 1'b1);
      chk("lb_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h2);
      chk("lb_sel", 32'(ram_select), 32'h8);
      tick();
      chk("lb_data", wb_wdata, 32'hFFFF_FF80);
      chk("lb_wd", 32'(wb_wd), 32'd5);
      chk("lb_wreg", 32'(wb_wreg), 32'd1);
      drive(4'd2, 32'h0000_0001, 5'd6, 1'b1);
      tick();
      chk("lbu_data", wb_wdata, 32'h0000_00FF);
      drive(4'd3, 32'h0000_0002, 5'd7, 1'b1);
      tick();
      chk("lh_data", wb_wdata, 32'h0000_7F01);
      drive(4'd3, 32'h0000_0000, 5'd7, 1'b1);
      tick();
      chk("lh_neg", wb_wdata, 32'hFFFF_80FF);
      drive(4'd4, 32'h0000_0000, 5'd8, 1'b1);
      tick();
      chk("lhu_data", wb_wdata, 32'h0000_80FF);
      drive(4'd1, 32'h0000_0003, 5'd8, 1'b1);
      tick();
      chk("lb3_data", wb_wdata, 32'h0000_0001);
      drive(4'd5, 32'h0000_0000, 5'd9, 1'b1);
      tick();
      chk("lw_data", wb_wdata, 32'h80FF_7F01);

      // Misaligned LW
      drive(4'd5, 32'h0000_0002, 5'd9, 1'b1);
      chk("lw_mis_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h0);
      tick();
      chk("lw_mis_exc", {30'd0, exc_adel, exc_ades}, 32'h2);
      chk("lw_mis_vaddr", bad_vaddr, 32'h0000_0002);
      chk("lw_mis_wreg", 32'(wb_wreg), 32'd0);

      // Non-memory op; exception is single-cycle
      alu_result_in = 32'h1234_5678;
      drive(4'd0, 32'h0000_0003, 5'd3, 1'b1);
      chk("nop_sel", 32'(ram_select), 32'h0);
      chk("nop_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h0);
      tick();
      chk("nop_data", wb_wdata, 32'h1234_5678);
      chk("nop_exc", {30'd0, exc_adel, exc_ades}, 32'h0);
      chk("nop_wreg", 32'(wb_wreg), 32'd1);

      // Misaligned SH
      drive(4'd7, 32'h0000_0001, 5'd0, 1'b0);
      chk("sh_mis_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h0);
      tick();
      chk("sh_mis_exc", {30'd0, exc_adel, exc_ades}, 32'h1);
      chk("sh_mis_vaddr", bad_vaddr, 32'h0000_0001);

      // SW stalled for two cycles, then committed
      mem_store_data = 32'hDEAD_BEEF;
      alu_result_in  = 32'hCAFE_0000;
      stall = 1'b1;
      drive(4'd8, 32'h0000_0008, 5'd0, 1'b0);
      chk("sw_stall_we0", 32'(ram_write_enabler), 32'd0);
      chk("sw_stall_din", ram_data_input, 32'hDEAD_BEEF);
      tick();
      chk("sw_stall_we1", 32'(ram_write_enabler), 32'd0);
      chk("sw_stall_hold", wb_wdata, 32'h1234_5678);
      chk("sw_stall_exc", {30'd0, exc_adel, exc_ades}, 32'h1);
      tick();
      chk("sw_stall_hold2", wb_wdata, 32'h1234_5678);
      stall = 1'b0;
      #1;
      chk("sw_go_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h3);
      chk("sw_go_sel", 32'(ram_select), 32'hF);
      tick();
      chk("sw_go_exc", {30'd0, exc_adel, exc_ades}, 32'h0);
      chk("sw_go_data", wb_wdata, 32'hCAFE_0000);

      // Flush: store suppressed, loaded op squashed
      flush = 1'b1;
      drive(4'd8, 32'h0000_0004, 5'd0, 1'b0);
      chk("flush_we", 32'(ram_write_enabler), 32'd0);
      drive(4'd5, 32'h0000_0001, 5'd4, 1'b1);
      tick();
      chk("flush_wreg", 32'(wb_wreg), 32'd0);
      chk("flush_exc", {30'd0, exc_adel, exc_ades}, 32'h0);
      flush = 1'b0;

`ifdef MEM_STAGE_LLSC_EN
      mem_store_data = 32'h0000_0055;
      drive(4'd9, 32'h0000_0010, 5'd2, 1'b1);
      chk("ll_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h2);
      tick();
      chk("ll_data", wb_wdata, 32'h80FF_7F01);
      drive(4'd10, 32'h0000_0010, 5'd2, 1'b1);
      chk("sc1_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h3);
      tick();
      chk("sc1_data", wb_wdata, 32'd1);
      chk("sc2_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h0);
      tick();
      chk("sc2_data", wb_wdata, 32'd0);
      drive(4'd9, 32'h0000_0010, 5'd2, 1'b1);
      tick();
      ll_clear = 1'b1;
      drive(4'd0, 32'h0000_0010, 5'd2, 1'b0);
      tick();
      ll_clear = 1'b0;
      drive(4'd10, 32'h0000_0010, 5'd2, 1'b1);
      chk("sc3_we", 32'(ram_write_enabler), 32'd0);
      tick();
      chk("sc3_data", wb_wdata, 32'd0);
`else
      drive(4'd9, 32'h0000_0010, 5'd2, 1'b1);
      chk("ll_off_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h0);
      tick();
      chk("ll_off_wreg", 32'(wb_wreg), 32'd0);
      drive(4'd10, 32'h0000_0010, 5'd2, 1'b1);
      chk("sc_off_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h0);
      tick();
      chk("sc_off_wreg", 32'(wb_wreg), 32'd0);
`endif

      // Reset in the middle of a store
      drive(4'd5, 32'h0000_0000, 5'd9, 1'b1);
      tick();
      chk("pre_rst_wreg", 32'(wb_wreg), 32'd1);
      drive(4'd8, 32'h0000_0000, 5'd0, 1'b0);
      chk("pre_rst_we", 32'(ram_write_enabler), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_sw_en", {30'd0, ram_enabler, ram_write_enabler}, 32'h0);
      chk("rst_sw_wreg", 32'(wb_wreg), 32'd0);
      chk("rst_sw_wdata", wb_wdata, 32'd0);
      chk("rst_sw_wd", 32'(wb_wd), 32'd0);
      tick();
      chk("rst_sw_hold_we", 32'(ram_write_enabler), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
